// File: rtl/afe_regs_pkg.sv
// Shared AFE4490 register map definitions.
// Contents: register address constants, CONTROL0 bit positions, SPI frame
// length and the SPI frame FSM state encoding. Also used by spibufferv3 and
// write_ramv1.
package afe_regs_pkg;

  localparam logic [7:0] CONTROL0      = 8'h00;
  localparam logic [7:0] LAST_WRITABLE = 8'h29;
  localparam logic [7:0] LED2VAL       = 8'h2A;
  localparam logic [7:0] ALED2VAL      = 8'h2B;
  localparam logic [7:0] LED1VAL       = 8'h2C;
  localparam logic [7:0] ALED1VAL      = 8'h2D;
  localparam logic [7:0] LED2_ALED2VAL = 8'h2E;
  localparam logic [7:0] LED1_ALED1VAL = 8'h2F;
  localparam logic [7:0] DIAG          = 8'h30;

  localparam int CTL0_SPI_READ = 0;
  localparam int CTL0_DIAG_EN  = 2;
  localparam int CTL0_SW_RST   = 3;

  localparam int FRAME_LEN = 32;
  localparam int SAMPLE_W  = 22;
  localparam int FLAGS_W   = 21;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Synchroniser for the SPI pins plus edge pulses on the synchronised copies.
// Ports: clk/reset (sync, active-high); sclk, cs_n, mosi asynchronous inputs;
// sclk_rise/sclk_fall/cs_rise/cs_fall single-cycle pulses; mosi_s synced data.
// SYNC_STAGES must be >= 2.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr;
  logic                   sclk_d, cs_d;

  // cs_n resets to the asserted level so that a chip select already held low
  // across reset does not look like a new frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sr <= '0;
      cs_sr   <= '0;
      mosi_sr <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      sclk_d  <= sclk_sr[SYNC_STAGES-1];
      cs_d    <= cs_sr[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sr[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_sr[SYNC_STAGES-1] & sclk_d;
  assign cs_rise   = cs_sr[SYNC_STAGES-1] & ~cs_d;
  assign cs_fall   = ~cs_sr[SYNC_STAGES-1] & cs_d;
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];

endmodule

// File: rtl/afe_spi_responder.sv
// AFE4490 register-interface stand-in: SPI mode-0 responder with a flop
// register file, sample injection into the result registers, adc_rdy and
// optional diagnostic model.
// Ports: clk/reset (sync, active-high); sclk/cs_n/mosi/miso SPI pins;
// in_sample_valid + in_led2/in_aled2/in_led1/in_aled1 sample load;
// in_diag_flags copied into DIAG on diagnostic completion; adc_rdy,
// diag_end, out_txn_done pulses; out_spi_read_en mirrors CONTROL0.SPI_READ.
// Build option: define AFE_DIAG_MODEL_EN to enable the DIAG_EN countdown
// model; otherwise DIAG_EN is a plain stored bit and diag_end stays 0.
module afe_spi_responder
  import afe_regs_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 24,
  parameter int NUM_REGS    = 49,
  parameter int SYNC_STAGES = 2,
  parameter int DIAG_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                cs_n,
  input  logic                mosi,
  output logic                miso,
  input  logic                in_sample_valid,
  input  logic [SAMPLE_W-1:0] in_led2,
  input  logic [SAMPLE_W-1:0] in_aled2,
  input  logic [SAMPLE_W-1:0] in_led1,
  input  logic [SAMPLE_W-1:0] in_aled1,
  input  logic [FLAGS_W-1:0]  in_diag_flags,
  output logic                adc_rdy,
  output logic                diag_end,
  output logic                out_spi_read_en,
  output logic                out_txn_done
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(FRAME_LEN);

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a);
  endfunction

  function automatic logic signed [DATA_W-1:0] sext(input logic [SAMPLE_W-1:0] v);
    return {{(DATA_W-SAMPLE_W){v[SAMPLE_W-1]}}, v};
  endfunction

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall),
    .mosi_s   (mosi_s)
  );

  spi_state_t               state, state_nxt;
  logic [CNT_W-1:0]         bit_cnt;
  logic [FRAME_LEN-2:0]     rx_sr;
  logic [DATA_W-1:0]        tx_sr;
  logic                     miso_r;
  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic                     frame_start, rx_shift, tx_load, tx_shift, commit;
  logic [ADDR_W-1:0]        rd_addr, wr_addr;
  logic [DATA_W-1:0]        rd_data, wr_data;
  logic                     spi_read, wr_ok, sw_rst, diag_done;
  logic signed [DATA_W-1:0] led2_x, aled2_x, led1_x, aled1_x;

  // ---- frame FSM: state register / next state / decoded actions ----
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_nxt = ST_ADDR;
        ST_ADDR: if (sclk_rise && bit_cnt == CNT_W'(ADDR_W-1)) state_nxt = ST_DATA;
        ST_DATA: if (sclk_rise && bit_cnt == CNT_W'(FRAME_LEN-1)) state_nxt = ST_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // A cs_n rise pre-empts everything, so an incomplete frame never commits.
  always_comb begin
    frame_start = 1'b0;
    rx_shift    = 1'b0;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;
    commit      = 1'b0;
    if (!cs_rise) begin
      case (state)
        ST_IDLE: frame_start = cs_fall;
        ST_ADDR: begin
          rx_shift = sclk_rise;
          tx_load  = sclk_rise && bit_cnt == CNT_W'(ADDR_W-1);
        end
        ST_DATA: begin
          rx_shift = sclk_rise;
          tx_shift = sclk_fall;
          commit   = sclk_rise && bit_cnt == CNT_W'(FRAME_LEN-1);
        end
        default: ;
      endcase
    end
  end

  // ---- shift registers ----
  assign spi_read = regs[idx(CONTROL0)][CTL0_SPI_READ];
  assign rd_addr  = {rx_sr[ADDR_W-2:0], mosi_s};
  assign rd_data  = (spi_read && rd_addr < ADDR_W'(NUM_REGS)) ? regs[idx(rd_addr)] : '0;
  assign wr_addr  = rx_sr[FRAME_LEN-2 -: ADDR_W];
  assign wr_data  = {rx_sr[DATA_W-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      miso_r  <= 1'b0;
    end else begin
      if (rx_shift) begin
        rx_sr   <= {rx_sr[FRAME_LEN-3:0], mosi_s};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      // Readback is a snapshot taken at the 8th rise.
      if (tx_load) tx_sr <= rd_data;
      if (tx_shift) begin
        miso_r <= tx_sr[DATA_W-1];
        tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign miso = (state == ST_DATA) && miso_r;

  // ---- write commit ----
  assign wr_ok  = commit && (!spi_read || wr_addr == CONTROL0) && wr_addr <= LAST_WRITABLE;
  assign sw_rst = wr_ok && wr_addr == CONTROL0 && wr_data[CTL0_SW_RST];

`ifdef AFE_DIAG_MODEL_EN
  localparam int DCNT_W = $clog2(DIAG_CYCLES + 1);
  logic              diag_busy, diag_start;
  logic [DCNT_W-1:0] diag_cnt;

  assign diag_start = wr_ok && wr_addr == CONTROL0 && wr_data[CTL0_DIAG_EN] && !sw_rst;
  assign diag_done  = diag_busy && diag_cnt == '0 && !diag_start && !sw_rst;

  // Loaded with DIAG_CYCLES-1 so completion lands DIAG_CYCLES clocks after commit.
  always_ff @(posedge clk) begin
    if (reset || sw_rst) begin
      diag_busy <= 1'b0;
      diag_cnt  <= '0;
      diag_end  <= 1'b0;
    end else begin
      diag_end <= diag_done;
      if (diag_start) begin
        diag_busy <= 1'b1;
        diag_cnt  <= DCNT_W'(DIAG_CYCLES - 1);
      end else if (diag_done) begin
        diag_busy <= 1'b0;
      end else if (diag_busy) begin
        diag_cnt <= diag_cnt - DCNT_W'(1);
      end
    end
  end
`else
  logic unused_diag;
  assign unused_diag = (DIAG_CYCLES == 0) | wr_data[CTL0_DIAG_EN];
  assign diag_done   = 1'b0;
  assign diag_end    = 1'b0;
`endif

  // ---- register file ----
  assign led2_x  = sext(in_led2);
  assign aled2_x = sext(in_aled2);
  assign led1_x  = sext(in_led1);
  assign aled1_x = sext(in_aled1);

  // SW_RST clears everything, including a same-cycle sample load.
  always_ff @(posedge clk) begin
    if (reset || sw_rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (wr_ok) regs[idx(wr_addr)] <= wr_data;
      if (diag_done) begin
        regs[idx(DIAG)] <= {{(DATA_W-FLAGS_W){1'b0}}, in_diag_flags};
        regs[idx(CONTROL0)][CTL0_DIAG_EN] <= 1'b0;
      end
      if (in_sample_valid) begin
        regs[idx(LED2VAL)]       <= led2_x;
        regs[idx(ALED2VAL)]      <= aled2_x;
        regs[idx(LED1VAL)]       <= led1_x;
        regs[idx(ALED1VAL)]      <= aled1_x;
        regs[idx(LED2_ALED2VAL)] <= led2_x - aled2_x;
        regs[idx(LED1_ALED1VAL)] <= led1_x - aled1_x;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_txn_done <= 1'b0;
      adc_rdy      <= 1'b0;
    end else begin
      out_txn_done <= commit;
      adc_rdy      <= in_sample_valid && !sw_rst;
    end
  end

  assign out_spi_read_en = spi_read;

endmodule

// File: tb/tb_afe_spi_responder.sv
// Self-checking bench for afe_spi_responder. A register-level model tracks
// the expected register contents and the clock cycles on which out_txn_done,
// adc_rdy and diag_end must pulse; a compare process checks those pulses on
// every cycle, and each frame checks the bits read back on miso.
// Honours AFE_DIAG_MODEL_EN in the same way as the design.
module tb_afe_spi_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        in_sample_valid = 1'b0;
  logic [21:0] in_led2 = '0, in_aled2 = '0, in_led1 = '0, in_aled1 = '0;
  logic [20:0] in_diag_flags = 21'h1555;
  logic        adc_rdy, diag_end, out_spi_read_en, out_txn_done;

  afe_spi_responder #(.DIAG_CYCLES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .sclk           (sclk),
    .cs_n           (cs_n),
    .mosi           (mosi),
    .miso           (miso),
    .in_sample_valid(in_sample_valid),
    .in_led2        (in_led2),
    .in_aled2       (in_aled2),
    .in_led1        (in_led1),
    .in_aled1       (in_aled1),
    .in_diag_flags  (in_diag_flags),
    .adc_rdy        (adc_rdy),
    .diag_end       (diag_end),
    .out_spi_read_en(out_spi_read_en),
    .out_txn_done   (out_txn_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic [23:0] m_regs [49];
  int exp_txn[$];
  int exp_adc[$];
  int exp_diag[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic e;
    if (chk_en) begin
      e = (exp_txn.size() > 0 && exp_txn[0] == cyc);
      if (e) void'(exp_txn.pop_front());
      check("txn_done", {31'b0, out_txn_done}, {31'b0, e});
      e = (exp_adc.size() > 0 && exp_adc[0] == cyc);
      if (e) void'(exp_adc.pop_front());
      check("adc_rdy", {31'b0, adc_rdy}, {31'b0, e});
      e = (exp_diag.size() > 0 && exp_diag[0] == cyc);
      if (e) void'(exp_diag.pop_front());
      check("diag_end", {31'b0, diag_end}, {31'b0, e});
    end
  end

  // ---- register-level model ----
  function automatic logic [23:0] sx(input logic [21:0] v);
    int s;
    s = v[21] ? int'(v) - 4194304 : int'(v);
    return 24'(s);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 49; i++) m_regs[i] = 24'h0;
  endtask

  task automatic model_samples();
    int l2, a2, l1, a1;
    l2 = int'(signed'(sx(in_led2)));
    a2 = int'(signed'(sx(in_aled2)));
    l1 = int'(signed'(sx(in_led1)));
    a1 = int'(signed'(sx(in_aled1)));
    m_regs[42] = 24'(l2);
    m_regs[43] = 24'(a2);
    m_regs[44] = 24'(l1);
    m_regs[45] = 24'(a1);
    m_regs[46] = 24'(l2 - a2);
    m_regs[47] = 24'(l1 - a1);
  endtask

  // Drive inputs at a negedge; adc_rdy expected on the following cycle.
  task automatic strobe(input logic [21:0] l2, input logic [21:0] a2,
                        input logic [21:0] l1, input logic [21:0] a1);
    in_led2 = l2; in_aled2 = a2; in_led1 = l1; in_aled1 = a1;
    in_sample_valid = 1'b1;
    model_samples();
    exp_adc.push_back(cyc + 1);
    @(negedge clk);
    in_sample_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One SPI frame, sclk half period of 4 clk. nrise < 32 aborts with cs_n.
  // strobe_rise != 0 pulses in_sample_valid so it lands on the same clock
  // as the responder's reaction to that sclk rise.
  task automatic frame(input logic [7:0] addr, input logic [23:0] data, input int nrise,
                       input int strobe_rise, output logic [23:0] rd);
    logic [31:0] f;
    logic [23:0] exp_rd;
    bit spi_rd, wr_ok, sw;
    int a, k32;
    f = {addr, data};
    a = int'(addr);
    spi_rd = m_regs[0][0];
    exp_rd = (spi_rd && a < 49) ? m_regs[a] : 24'h0;
    wr_ok = (!spi_rd || a == 0) && a <= 41;
    sw = wr_ok && a == 0 && data[3];
    rd = '0;
    k32 = 0;
    cs_n = 1'b0;
    for (int b = 31; b >= 0; b--) begin
      int r;
      mosi = f[b];
      repeat (4) @(negedge clk);
      if (b < 24) rd[b] = miso;
      sclk = 1'b1;
      r = 32 - b;
      if (r == 32) begin
        k32 = cyc;
        exp_txn.push_back(cyc + 3);
      end
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        if (r == strobe_rise && j == 1) begin
          in_sample_valid = 1'b1;
          model_samples();
          if (!(r == 32 && sw)) exp_adc.push_back(cyc + 1);
        end
        if (r == strobe_rise && j == 2) in_sample_valid = 1'b0;
      end
      sclk = 1'b0;
      if (r == nrise) break;
    end
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    if (nrise == 32) begin
      check($sformatf("rd[%02h]", addr), {8'h0, rd}, {8'h0, exp_rd});
      if (sw) begin
        model_clear();
      end else if (wr_ok) begin
        m_regs[a] = data;
`ifdef AFE_DIAG_MODEL_EN
        if (a == 0 && data[2]) exp_diag.push_back(k32 + 3 + 16);
`endif
      end
    end
  endtask

  task automatic pulse_sclk(input logic m);
    mosi = m;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  initial begin
    logic [23:0] rd;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst miso", {31'b0, miso}, 32'h0);
    check("rst adc_rdy", {31'b0, adc_rdy}, 32'h0);
    check("rst diag_end", {31'b0, diag_end}, 32'h0);
    check("rst txn_done", {31'b0, out_txn_done}, 32'h0);
    check("rst spi_read_en", {31'b0, out_spi_read_en}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    // Write, enable readback, read back.
    frame(8'h01, 24'h00ABCD, 32, 0, rd);
    frame(8'h00, 24'h000001, 32, 0, rd);
    check("spi_read_en on", {31'b0, out_spi_read_en}, 32'h1);
    frame(8'h01, 24'h000000, 32, 0, rd);
    check("lit rd01", {8'h0, rd}, 32'h00ABCD);

    // Sample injection with sign extension and differences.
    strobe(22'h3FFFFF, 22'h000001, 22'h000005, 22'h3FFFF0);
    for (int i = 42; i <= 47; i++) begin
      frame(8'(i), 24'h0, 32, 0, rd);
      if (i == 42) check("lit rd2A", {8'h0, rd}, 32'hFFFFFF);
      if (i == 46) check("lit rd2E", {8'h0, rd}, 32'hFFFFFE);
      if (i == 47) check("lit rd2F", {8'h0, rd}, 32'h000015);
    end
    // Sample load coinciding with the readback snapshot returns old data.
    in_led2 = 22'h000100;
    frame(8'h2A, 24'h0, 32, 8, rd);
    check("lit snapshot", {8'h0, rd}, 32'hFFFFFF);
    frame(8'h2A, 24'h0, 32, 0, rd);
    check("lit rd2A new", {8'h0, rd}, 32'h000100);

    // Writes to result registers are dropped.
    frame(8'h00, 24'h000000, 32, 0, rd);
    frame(8'h2C, 24'h123456, 32, 0, rd);
    frame(8'h30, 24'h0000AA, 32, 0, rd);
    frame(8'h29, 24'hC0FFEE, 32, 0, rd);
    // Aborted frame, then a normal one.
    frame(8'h05, 24'h777777, 20, 0, rd);
    frame(8'h06, 24'h000606, 32, 0, rd);
    frame(8'h00, 24'h000001, 32, 0, rd);
    frame(8'h2C, 24'h0, 32, 0, rd);
    check("lit rd2C kept", {8'h0, rd}, 32'h000005);
    frame(8'h05, 24'h0, 32, 0, rd);
    check("lit rd05 abort", {8'h0, rd}, 32'h000000);
    frame(8'h06, 24'h0, 32, 0, rd);
    frame(8'h29, 24'h0, 32, 0, rd);
    frame(8'h30, 24'h0, 32, 0, rd);
    frame(8'h40, 24'h0, 32, 0, rd);

    // SW_RST clears everything.
    frame(8'h00, 24'h000008, 32, 0, rd);
    check("spi_read_en swrst", {31'b0, out_spi_read_en}, 32'h0);
    frame(8'h00, 24'h000001, 32, 0, rd);
    frame(8'h01, 24'h0, 32, 0, rd);
    check("lit rd01 swrst", {8'h0, rd}, 32'h000000);
    // SW_RST in the same cycle as a sample load: SW_RST wins.
    strobe(22'h000123, 22'h000001, 22'h000456, 22'h000002);
    in_led2 = 22'h0000AA;
    frame(8'h00, 24'h000008, 32, 32, rd);
    frame(8'h00, 24'h000001, 32, 0, rd);
    frame(8'h2A, 24'h0, 32, 0, rd);
    frame(8'h2E, 24'h0, 32, 0, rd);

    // Reset in the middle of a frame with cs_n held low.
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) pulse_sclk(1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 22; i++) pulse_sclk(1'b0);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("spi_read_en rst", {31'b0, out_spi_read_en}, 32'h0);
    frame(8'h01, 24'h00BEEF, 32, 0, rd);
    frame(8'h00, 24'h000001, 32, 0, rd);
    frame(8'h01, 24'h0, 32, 0, rd);

    // Diagnostic model.
    frame(8'h00, 24'h000005, 32, 0, rd);
    repeat (30) @(negedge clk);
`ifdef AFE_DIAG_MODEL_EN
    m_regs[48] = {3'b0, in_diag_flags};
    m_regs[0][2] = 1'b0;
`endif
    frame(8'h30, 24'h0, 32, 0, rd);
`ifdef AFE_DIAG_MODEL_EN
    check("lit DIAG", {8'h0, rd}, 32'h001555);
`else
    check("lit DIAG", {8'h0, rd}, 32'h000000);
`endif
    frame(8'h00, 24'h000001, 32, 0, rd);
    repeat (10) @(negedge clk);

    check("pending txn", exp_txn.size(), 32'h0);
    check("pending adc", exp_adc.size(), 32'h0);
    check("pending diag", exp_diag.size(), 32'h0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
